game_board_ctrl: RTL
====================

// Module: game_board_ctrl
// PURPOSE
//  Tic-tac-toe game controller. Owns the 3x3 board state, alternates X/O turns,
//  accepts square-select clicks and detects win/draw. Drives square enables and
//  colours for the nine per-square overlay stages (squares 1..9, row-major,
//  5 = centre). Displayed board updates only at frame start, so a frame never
//  shows a half-applied move.
// PARAMETERS
//  X_COLOR             12'hF00  rgb for squares owned by X
//  O_COLOR             12'h00F  rgb for squares owned by O
//  RESULT_HOLD_FRAMES  120      frames the final board is held before auto-clear (>=1)
// PORTS
//  pclk          in   1    pixel clock; only clock
//  rst           in   1    synchronous, active-high reset
//  start_en      in   1    game screen active
//  choice_en     in   1    choice menu active; blocks play while high
//  vblnk_in      in   1    vertical blank from timing chain; rising edge = frame start
//  click         in   1    one-cycle pulse: player selected a square
//  click_sq      in   4    selected square, valid 1..9 when click=1
//  click_ack     out  1    one-cycle pulse: click accepted as a move
//  square_en     out  9    bit i-1 high = square i occupied on display
//  square_color  out  108  colour of square i at [12*i-1 -: 12]; 12'h000 if empty
//  turn          out  1    0 = X to move, 1 = O to move
//  game_over     out  1    high in RESULT state
//  winner        out  2    00 none, 01 X, 10 O, 11 draw
// BEHAVIOUR
//  Reset: all outputs 0, boards cleared, turn=X, state IDLE, counters 0.
//  play_ok = start_en & ~choice_en. All outputs registered.
//  Boards: shadow pair xs/os[8:0] (state); display pair xd/od[8:0] drives outputs.
//   On vblnk_in rising edge (registered edge detect): xd<=xs, od<=os.
//   square_en = xd|od; square_color slice = X_COLOR if xd, O_COLOR if od, else 0.
//  FSM:
//   IDLE   : boards cleared, turn=X, winner=00. play_ok -> TURN.
//   TURN   : click & click_sq in 1..9 & square empty in xs|os -> set bit for
//            current player, click_ack=1 next cycle, -> CHECK. Invalid square
//            (0,10..15) or occupied -> ignored, no ack, stay.
//   CHECK  : evaluate 8 lines (3 rows, 3 cols, 2 diagonals), one per cycle via
//            3-bit line counter 0..7, for the player who just moved only.
//            Hit -> winner=01/10, -> RESULT. After line 7 without hit: all 9
//            occupied -> winner=11, -> RESULT; else toggle turn, -> TURN.
//            CHECK lasts 1..8 cycles; clicks during CHECK dropped, no ack.
//   RESULT : game_over=1; frame counter increments per vblnk rising edge; at
//            RESULT_HOLD_FRAMES -> clear shadow boards, winner=00, turn=X,
//            -> TURN (cleared board displayed at next frame start).
//  play_ok low in any state (not a click) -> IDLE next cycle, boards cleared;
//   display boards clear at next frame start.
//  Simultaneous: click and vblnk edge in same cycle -> move lands in shadow,
//   displayed one frame later. play_ok drop wins over click.
//  rst mid-game: identical to power-up reset, in-progress move discarded.
// STRUCTURE
//  Shared package: state encoding (IDLE/TURN/CHECK/RESULT), winner codes,
//   8-entry win-line mask table (9-bit masks).
//  One sub-module: board_line_checker (comb: mask index + player board -> hit).
// TESTING
//  1 Reset then start_en=1, choice_en=0, click sq5 -> click_ack, xs[4]=1; after
//    next vblnk edge square_en=9'h010, colour slice 5=12'hF00, turn=1.
//  2 X:1, O:4, X:2, O:5, X:3 -> winner=01 within 8 cycles of last ack,
//    game_over=1; no further acks for clicks until auto-clear.
//  3 Click occupied sq5 again, and click_sq=0 / 10 -> no ack, boards unchanged.
//  4 Full-board draw (X:1,O:2,X:3,O:5,X:4,O:6,X:8,O:7,X:9) -> winner=11;
//    after RESULT_HOLD_FRAMES(=2 in bench) vblnk edges boards empty, turn=X.
//  5 choice_en=1 mid-game -> IDLE, click ignored; square_en=0 after next vblnk.
//  6 Click and vblnk edge same cycle -> square_en unchanged that frame, set
//    next frame; rst asserted during CHECK -> all outputs 0 next cycle.

Source files
------------

// File: rtl/game_board_ctrl_pkg.sv
// game_board_ctrl_pkg: shared state encoding, winner codes and win-line masks
package game_board_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_TURN, S_CHECK, S_RESULT} state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  localparam logic [7:0][8:0] WIN_LINES = {
    9'b001_010_100,
    9'b100_010_001,
    9'b100_100_100,
    9'b010_010_010,
    9'b001_001_001,
    9'b111_000_000,
    9'b000_111_000,
    9'b000_000_111
  };
endpackage

// File: rtl/game_board_ctrl_board_line_checker.sv
// board_line_checker: flags when a player's board covers the selected win line
module board_line_checker
  import game_board_ctrl_pkg::*;
(
  input  logic [2:0] i_line,
  input  logic [8:0] i_board,
  output logic       o_hit
);
  assign o_hit = (i_board & WIN_LINES[i_line]) == WIN_LINES[i_line];
endmodule

// File: rtl/game_board_ctrl.sv
// game_board_ctrl: tic-tac-toe controller with shadow/display boards and frame-synced updates
module game_board_ctrl
  import game_board_ctrl_pkg::*;
#(
  parameter logic [11:0] X_COLOR            = 12'hF00,
  parameter logic [11:0] O_COLOR            = 12'h00F,
  parameter int          RESULT_HOLD_FRAMES = 120
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         start_en,
  input  logic         choice_en,
  input  logic         vblnk_in,
  input  logic         click,
  input  logic [3:0]   click_sq,
  output logic         click_ack,
  output logic [8:0]   square_en,
  output logic [107:0] square_color,
  output logic         turn,
  output logic         game_over,
  output logic [1:0]   winner
);
  localparam int FW = $clog2(RESULT_HOLD_FRAMES + 1);
  state_t        r_state, w_state;
  logic [8:0]    r_xs, r_os, r_xd, r_od, w_xs, w_os, w_sq_mask;
  logic          r_turn, w_turn, r_ack, w_ack, r_vblnk;
  logic          w_vedge, w_play_ok, w_valid, w_hit;
  logic [1:0]    r_winner, w_winner;
  logic [2:0]    r_line, w_line;
  logic [FW-1:0] r_frames, w_frames;
  assign w_play_ok = start_en & ~choice_en;
  assign w_vedge   = vblnk_in & ~r_vblnk;
  assign w_sq_mask = 9'd1 << (click_sq - 4'd1);
  assign w_valid   = click && click_sq >= 4'd1 && click_sq <= 4'd9 && ((r_xs | r_os) & w_sq_mask) == 9'd0;
  board_line_checker u_checker (
    .i_line (r_line),
    .i_board(r_turn ? r_os : r_xs),
    .o_hit  (w_hit)
  );
  // next-state: move placement, line-by-line win scan, result hold and play_ok drop
  always_comb begin
    w_state  = r_state;
    w_xs     = r_xs;
    w_os     = r_os;
    w_turn   = r_turn;
    w_winner = r_winner;
    w_line   = r_line;
    w_frames = r_frames;
    w_ack    = 1'b0;
    if (!w_play_ok) begin
      w_state  = S_IDLE;
      w_xs     = '0;
      w_os     = '0;
      w_turn   = 1'b0;
      w_winner = WIN_NONE;
      w_line   = '0;
      w_frames = '0;
    end else begin
      case (r_state)
        S_IDLE: w_state = S_TURN;
        S_TURN: if (w_valid) begin
          w_xs    = r_turn ? r_xs : r_xs | w_sq_mask;
          w_os    = r_turn ? r_os | w_sq_mask : r_os;
          w_ack   = 1'b1;
          w_line  = '0;
          w_state = S_CHECK;
        end
        S_CHECK: if (w_hit) begin
          w_winner = r_turn ? WIN_O : WIN_X;
          w_frames = '0;
          w_state  = S_RESULT;
        end else if (r_line == 3'd7) begin
          w_winner = (r_xs | r_os) == 9'h1FF ? WIN_DRAW : WIN_NONE;
          w_turn   = (r_xs | r_os) == 9'h1FF ? r_turn : ~r_turn;
          w_frames = '0;
          w_state  = (r_xs | r_os) == 9'h1FF ? S_RESULT : S_TURN;
        end else begin
          w_line = r_line + 3'd1;
        end
        S_RESULT: if (w_vedge) begin
          if (r_frames == FW'(RESULT_HOLD_FRAMES - 1)) begin
            w_xs     = '0;
            w_os     = '0;
            w_turn   = 1'b0;
            w_winner = WIN_NONE;
            w_frames = '0;
            w_state  = S_TURN;
          end else begin
            w_frames = r_frames + FW'(1);
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end
  // state registers; display boards latch the shadow boards at each frame start
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_xs     <= '0;
      r_os     <= '0;
      r_xd     <= '0;
      r_od     <= '0;
      r_turn   <= 1'b0;
      r_ack    <= 1'b0;
      r_vblnk  <= 1'b0;
      r_winner <= WIN_NONE;
      r_line   <= '0;
      r_frames <= '0;
    end else begin
      r_state  <= w_state;
      r_xs     <= w_xs;
      r_os     <= w_os;
      r_turn   <= w_turn;
      r_ack    <= w_ack;
      r_vblnk  <= vblnk_in;
      r_winner <= w_winner;
      r_line   <= w_line;
      r_frames <= w_frames;
      if (w_vedge) begin
        r_xd <= r_xs;
        r_od <= r_os;
      end
    end
  end
  for (genvar i = 0; i < 9; i++) begin : g_color
    assign square_color[12*i +: 12] = r_xd[i] ? X_COLOR : r_od[i] ? O_COLOR : 12'h000;
  end
  assign click_ack = r_ack;
  assign square_en = r_xd | r_od;
  assign turn      = r_turn;
  assign winner    = r_winner;
  assign game_over = r_state == S_RESULT;
endmodule
